// File: rtl/image_row_window.sv
// ============================================================================
// Module      : image_row_window
// Description : Streaming 3-row column generator; two distributed row RAMs
//               hold rows r-2 and r-1, output {r-2, r-1, r} per pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_row_window #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10,
    parameter int ROW_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] col_num,
    input  logic [ROW_BITS-1:0]  row_num,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [3*WIDTH-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int C_DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_col_num;
    logic [ADDR_BITS-1:0] r_col_cnt;
    logic [ROW_BITS-1:0]  r_row_num;
    logic [ROW_BITS-1:0]  r_row_cnt;
    logic [WIDTH-1:0]     r_ram_a [C_DEPTH];
    logic [WIDTH-1:0]     r_ram_b [C_DEPTH];

    logic                 w_acc;
    logic                 w_col_last;
    logic [WIDTH-1:0]     w_rd2;
    logic [WIDTH-1:0]     w_rd1;

    always_comb begin
        s_ready = 1'b0;
        case (r_state)
            FILL:    s_ready = 1'b1;
            RUN:     s_ready = !m_valid || m_ready;
            default: s_ready = 1'b0;
        endcase
    end

    assign w_acc      = s_valid && s_ready;
    assign w_col_last = (r_col_cnt == r_col_num);
    assign w_rd2      = r_ram_a[r_col_cnt];
    assign w_rd1      = r_ram_b[r_col_cnt];

    // Row shift: A takes the old B word, B takes the incoming pixel.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_ram_a[r_col_cnt] <= w_rd1;
            r_ram_b[r_col_cnt] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_col_num <= '0;
            r_row_num <= '0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_col_num <= col_num;
                        r_row_num <= row_num;
                        r_col_cnt <= '0;
                        r_row_cnt <= '0;
                        busy      <= 1'b1;
                        r_state   <= (row_num < ROW_BITS'(2)) ? FIN : FILL;
                    end
                end
                FILL: begin
                    if (w_acc && w_col_last && (r_row_cnt == ROW_BITS'(1))) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_acc) begin
                        m_data  <= {w_rd2, w_rd1, s_data};
                        m_valid <= 1'b1;
                        if (w_col_last && (r_row_cnt == r_row_num)) begin
                            r_state <= DRAIN;
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!m_valid || m_ready) begin
                        m_valid <= 1'b0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Accepts only happen in FILL/RUN, so this never collides with the IDLE clear.
            if (w_acc) begin
                if (w_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_image_row_window.sv
// ============================================================================
// Module      : tb_image_row_window
// Description : Randomized scoreboard bench for image_row_window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_row_window;

    localparam int W  = 8;
    localparam int AB = 10;
    localparam int RB = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AB-1:0] col_num;
    logic [RB-1:0] row_num;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [3*W-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic          done;

    image_row_window #(.WIDTH(W), .ADDR_BITS(AB), .ROW_BITS(RB)) dut (
        .clk(clk), .rst(rst), .start(start), .col_num(col_num), .row_num(row_num),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              out_cnt  = 0;
    logic [3*W-1:0]  exp_q [$];
    bit              held     = 1'b0;
    logic [3*W-1:0]  held_data;
    logic [3*W-1:0]  exp_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Monitor: handshakes pop the scoreboard; stalls must hold data and block input.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'(m_data), 32'(held_data));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_output: got %h expected none", m_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("m_data", 32'(m_data), 32'(exp_word));
                        out_cnt++;
                    end
                    held = 1'b0;
                end else if (m_valid) begin
                    check("stall_s_ready", 32'(s_ready), 32'd0);
                    held      = 1'b1;
                    held_data = m_data;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_frame(input int cols, input int rows, input bit pattern, input int vpct,
                             input int rmode, input int rst_after, input bit inj_start,
                             output int done_iter);
        logic [W-1:0] pq [$];
        int n, idx, exp_acc, iter;
        bit acc, fin, injected;
        n = (cols + 1) * (rows + 1);
        for (int r = 0; r <= rows; r++)
            for (int c = 0; c <= cols; c++)
                pq.push_back(pattern ? W'(r * 16 + c) : W'($urandom));
        if (rows >= 2)
            for (int r = 2; r <= rows; r++)
                for (int c = 0; c <= cols; c++)
                    exp_q.push_back({pq[(r-2)*(cols+1)+c], pq[(r-1)*(cols+1)+c], pq[r*(cols+1)+c]});
        exp_acc   = (rows >= 2) ? n : 0;
        out_cnt   = 0;
        idx       = 0;
        iter      = 0;
        fin       = 1'b0;
        injected  = 1'b0;
        done_iter = -1;
        @(negedge clk);
        while (!fin) begin
            start = 1'b0;
            if (iter == 0) begin
                start   = 1'b1;
                col_num = AB'(cols);
                row_num = RB'(rows);
            end else if (inj_start && !injected && idx == 2 * (cols + 1) + 1) begin
                start    = 1'b1;
                col_num  = AB'(cols + 5);
                row_num  = RB'(1);
                injected = 1'b1;
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (iter % 4 == 0) || (iter % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (idx < n && $urandom_range(0, 99) < vpct) begin
                s_valid = 1'b1;
                s_data  = pq[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
            end
            #1;
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            iter++;
            if (iter == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (done) begin
                fin       = 1'b1;
                done_iter = iter - 1;
            end
            if (rst_after > 0 && out_cnt >= rst_after) begin
                rst = 1'b1;
                #1;
                check("rst_m_valid", 32'(m_valid), 32'd0);
                check("rst_m_data", 32'(m_data), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_s_ready", 32'(s_ready), 32'd0);
                #2;
                rst = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end
            if (iter > 20000) begin
                n_checks++;
                $display("FAIL frame_timeout: got no done after %0d cycles, required done", iter);
                fin = 1'b1;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (rst_after == 0) begin
            check("accepted_pixels", 32'(idx), 32'(exp_acc));
            check("outputs_left", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
        end
    endtask

    int d;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        col_num = '0;
        row_num = '0;
        repeat (3) @(negedge clk);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;

        run_frame(3, 3, 1'b1, 100, 0, 0, 1'b0, d);
        run_frame(3, 3, 1'b1, 100, 1, 0, 1'b0, d);
        run_frame(3, 3, 1'b1, 50, 0, 0, 1'b0, d);
        run_frame(3, 1, 1'b0, 100, 0, 0, 1'b0, d);
        check("done_latency_short_frame", 32'(d), 32'd1);
        run_frame(0, 2, 1'b0, 100, 0, 0, 1'b0, d);
        run_frame(3, 3, 1'b1, 100, 0, 5, 1'b0, d);
        run_frame(3, 3, 1'b1, 100, 0, 0, 1'b0, d);
        run_frame(3, 3, 1'b1, 100, 0, 0, 1'b1, d);
        for (int k = 0; k < 4; k++)
            run_frame(int'($urandom_range(0, 20)), int'($urandom_range(2, 8)), 1'b0,
                      int'($urandom_range(30, 100)), 2, 0, 1'b0, d);
        run_frame(1023, 2, 1'b0, 100, 2, 0, 1'b0, d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
